// File: rtl/vga_text_pkg.sv
// Shared constants and types for the VGA text-mode blocks.
package vga_text_pkg;

    localparam int          VT_COLS       = 80;     // character columns per row
    localparam int          VT_ROWS       = 30;     // character rows per screen
    localparam int          VT_AW         = 12;     // VRAM address width
    localparam int          CELL_W        = 8;      // pixels per cell, horizontal
    localparam int          CELL_H        = 16;     // pixels per cell, vertical
    localparam logic [7:0]  VT_CLEAR_CHAR = 8'h20;  // blank (space)

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } arb_state_e;

endpackage

// File: rtl/vga_text_addr_gen.sv
// Maps a pixel coordinate to its character-cell address: (y/CELL_H)*COLS + x/CELL_W.
// Purely combinational so the cursor/overlay blocks can reuse it.
module vga_text_addr_gen
    import vga_text_pkg::*;
#(
    parameter int COLS = VT_COLS,
    parameter int AW   = VT_AW
) (
    input  logic [9:0]    i_x,
    input  logic [8:0]    i_y,
    output logic [AW-1:0] o_addr
);

    localparam int XS = $clog2(CELL_W);
    localparam int YS = $clog2(CELL_H);

    logic [31:0] w_col;
    logic [31:0] w_row;

    assign w_col  = 32'(i_x) >> XS;
    assign w_row  = 32'(i_y) >> YS;
    // COLS is a constant, so this is a constant-coefficient multiply; the
    // result fits AW bits for every on-screen coordinate.
    assign o_addr = AW'(w_row * 32'(COLS) + w_col);

endmodule

// File: rtl/vga_text_vram_arbiter.sv
// Single-port text VRAM arbiter: the display fetch owns one cycle per
// 8-pixel cell, the host port and the screen-clear engine share the rest.
module vga_text_vram_arbiter
    import vga_text_pkg::*;
#(
    parameter int         COLS       = VT_COLS,
    parameter int         ROWS       = VT_ROWS,
    parameter int         AW         = VT_AW,
    parameter logic [7:0] CLEAR_CHAR = VT_CLEAR_CHAR
) (
    input  logic          i_clk,
    input  logic          i_rst,          // async, active low
    // lookahead fetch coordinates from the timing generator
    input  logic          i_fetch_on,
    input  logic [9:0]    i_fetch_x,
    input  logic [8:0]    i_fetch_y,
    // host request/response
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_we,
    input  logic [AW-1:0] i_req_addr,
    input  logic [7:0]    i_req_wdata,
    output logic          o_rsp_valid,
    output logic [7:0]    o_rsp_rdata,
    // clear engine
    input  logic          i_clear_start,
    output logic          o_clear_busy,
    // VRAM port
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [7:0]    o_mem_wdata,
    input  logic [7:0]    i_mem_rdata,
    // glyph stage
    output logic [7:0]    o_char_code,
    output logic          o_char_valid
);

    localparam int            CELLS     = COLS * ROWS;
    localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);

    arb_state_e    r_state;
    logic [AW-1:0] r_cnt;
    logic          r_busy;
    logic          r_slot_d;
    logic          r_char_valid;
    logic [7:0]    r_char_code;
    logic          r_rsp_valid;

    logic          w_slot;
    logic          w_ready;
    logic          w_accept;
    logic [AW-1:0] w_fetch_addr;

    vga_text_addr_gen #(
        .COLS (COLS),
        .AW   (AW)
    ) u_addr_gen (
        .i_x    (i_fetch_x),
        .i_y    (i_fetch_y),
        .o_addr (w_fetch_addr)
    );

    // First pixel of a visible cell: the display owns the RAM this cycle.
    assign w_slot   = i_fetch_on && (i_fetch_x[2:0] == 3'd0);
    // Ready does not look at valid; clear_start beats a same-cycle request.
    assign w_ready  = i_rst && (r_state == IDLE) && !w_slot && !i_clear_start;
    assign w_accept = i_req_valid && w_ready;

    assign o_req_ready  = w_ready;
    assign o_clear_busy = r_busy;
    assign o_char_code  = r_char_code;
    assign o_char_valid = r_char_valid;
    assign o_rsp_valid  = r_rsp_valid;
    // RAM data arrives one cycle after the accept, together with rsp_valid.
    assign o_rsp_rdata  = r_rsp_valid ? i_mem_rdata : 8'h00;

    // Memory-port mux: display slot, then clear engine, then host.
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = 8'h00;
        if (!i_rst) begin
            o_mem_en = 1'b0;
        end else if (w_slot) begin
            o_mem_en   = 1'b1;
            o_mem_addr = w_fetch_addr;
        end else if (r_state == CLEAR) begin
            o_mem_en    = 1'b1;
            o_mem_we    = 1'b1;
            o_mem_addr  = r_cnt;
            o_mem_wdata = CLEAR_CHAR;
        end else if (w_accept) begin
            o_mem_en    = 1'b1;
            o_mem_we    = i_req_we;
            o_mem_addr  = i_req_addr;
            o_mem_wdata = i_req_wdata;
        end
    end

    // Arbitration FSM and clear counter; busy is registered with the state.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_clear_start) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // A display slot steals the cycle; the counter just waits.
                    // clear_start is ignored here, so no restart.
                    if (!w_slot) begin
                        if (r_cnt == LAST_CELL) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + AW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Display return path: capture RAM data the cycle after a slot.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_slot_d     <= 1'b0;
            r_char_valid <= 1'b0;
            r_char_code  <= 8'h00;
        end else begin
            r_slot_d     <= w_slot;
            r_char_valid <= r_slot_d;
            if (r_slot_d) begin
                r_char_code <= i_mem_rdata;
            end
        end
    end

    // Host read response flag; reset drops any read still in flight.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rsp_valid <= 1'b0;
        end else begin
            r_rsp_valid <= w_accept && !i_req_we;
        end
    end

endmodule

// File: tb/tb_vga_text_vram_arbiter.sv
// Directed bench for vga_text_vram_arbiter with a synchronous-read VRAM model.
module tb_vga_text_vram_arbiter;

    logic        clk;
    logic        rst;
    logic        fetch_on;
    logic [9:0]  fetch_x;
    logic [8:0]  fetch_y;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [11:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        clear_start;
    logic        clear_busy;
    logic        mem_en;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [7:0]  char_code;
    logic        char_valid;

    logic [7:0]  vram [0:4095];

    int checks = 0;
    int errors = 0;

    vga_text_vram_arbiter #(
        .COLS(80), .ROWS(30), .AW(12), .CLEAR_CHAR(8'h20)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_fetch_on   (fetch_on),
        .i_fetch_x    (fetch_x),
        .i_fetch_y    (fetch_y),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_rdata  (rsp_rdata),
        .i_clear_start(clear_start),
        .o_clear_busy (clear_busy),
        .o_mem_en     (mem_en),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata),
        .o_char_code  (char_code),
        .o_char_valid (char_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // VRAM model: write-through, read data one cycle after the request.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) vram[mem_addr] <= mem_wdata;
            else        mem_rdata <= vram[mem_addr];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic host_write(input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        fetch_on = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; fetch_on = 1'b1; fetch_x = 10'd0; fetch_y = 9'd0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'd0; req_wdata = 8'h00;
        clear_start = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", req_ready); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
        checks++; if (clear_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", clear_busy); end
        checks++; if (char_valid !== 1'b0 || char_code !== 8'h00) begin errors++; $display("FAIL rst_char: got %b/%h want 0/00", char_valid, char_code); end
        checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 8'h00) begin errors++; $display("FAIL rst_rsp: got %b/%h want 0/00", rsp_valid, rsp_rdata); end
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0; fetch_on = 1'b0;
    endtask

    task automatic test_display();
        host_write(12'd162, 8'h41);
        @(negedge clk);
        fetch_on = 1'b1; fetch_x = 10'd16; fetch_y = 9'd32;
        #1;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'd162) begin errors++; $display("FAIL disp_addr: got en=%b we=%b addr=%0d want 1/0/162", mem_en, mem_we, mem_addr); end
        @(negedge clk);
        fetch_on = 1'b0;
        #1;
        checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL disp_early: char_valid=%b want 0", char_valid); end
        @(negedge clk); #1;
        checks++; if (char_valid !== 1'b1 || char_code !== 8'h41) begin errors++; $display("FAIL disp_char: got %b/%h want 1/41", char_valid, char_code); end
        @(negedge clk); #1;
        checks++; if (char_valid !== 1'b0) begin errors++; $display("FAIL disp_pulse: char_valid=%b want 0", char_valid); end
        // bottom-right cell and a non-slot pixel
        fetch_on = 1'b1; fetch_x = 10'd639; fetch_y = 9'd479;
        #1;
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL disp_noslot: mem_en=%b want 0", mem_en); end
        @(negedge clk);
        fetch_x = 10'd632;
        #1;
        checks++; if (mem_addr !== 12'd2399 || mem_en !== 1'b1) begin errors++; $display("FAIL disp_last: addr=%0d en=%b want 2399/1", mem_addr, mem_en); end
        @(negedge clk);
        fetch_on = 1'b0;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'd5; req_wdata = 8'h7E;
        #1;
        checks++; if (req_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'd5 || mem_wdata !== 8'h7E)
            begin errors++; $display("FAIL wr_same_cycle: rdy=%b en=%b we=%b addr=%0d d=%h want 1/1/1/5/7e", req_ready, mem_en, mem_we, mem_addr, mem_wdata); end
        @(negedge clk);
        req_we = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1 || mem_we !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_accept: rdy=%b we=%b rsp=%b want 1/0/0", req_ready, mem_we, rsp_valid); end
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h7E) begin errors++; $display("FAIL rd_rsp: got %b/%h want 1/7e", rsp_valid, rsp_rdata); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_pulse: rsp_valid=%b want 0", rsp_valid); end
        // out-of-range host address passes straight through
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'd2400; req_wdata = 8'h99;
        #1;
        checks++; if (mem_addr !== 12'd2400 || mem_we !== 1'b1) begin errors++; $display("FAIL wr_oor: addr=%0d we=%b want 2400/1", mem_addr, mem_we); end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_collision();
        host_write(12'd1, 8'h55);
        @(negedge clk);
        fetch_on = 1'b1; fetch_x = 10'd8; fetch_y = 9'd0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'd5;
        #1;
        checks++; if (req_ready !== 1'b0 || mem_addr !== 12'd1 || mem_we !== 1'b0) begin errors++; $display("FAIL col_stall: rdy=%b addr=%0d we=%b want 0/1/0", req_ready, mem_addr, mem_we); end
        @(negedge clk);
        fetch_x = 10'd9;
        #1;
        checks++; if (req_ready !== 1'b1 || mem_addr !== 12'd5) begin errors++; $display("FAIL col_accept: rdy=%b addr=%0d want 1/5", req_ready, mem_addr); end
        @(negedge clk);
        req_valid = 1'b0; fetch_on = 1'b0;
        #1;
        checks++; if (char_valid !== 1'b1 || char_code !== 8'h55) begin errors++; $display("FAIL col_char: got %b/%h want 1/55", char_valid, char_code); end
        checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 8'h7E) begin errors++; $display("FAIL col_rsp: got %b/%h want 1/7e", rsp_valid, rsp_rdata); end
    endtask

    task automatic test_clear_tie();
        int busy_cnt = 0;
        int bad = 0;
        bit saw_ready = 1'b0;
        bit done = 1'b0;
        @(negedge clk);
        fetch_on = 1'b0; clear_start = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'd7; req_wdata = 8'hAA;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL clr_tie: ready=%b want 0", req_ready); end
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            clear_start = 1'b0;
            #1;
            if (!clear_busy) done = 1'b1;
            else begin
                busy_cnt++;
                if (req_ready) saw_ready = 1'b1;
                if (busy_cnt == 100) clear_start = 1'b1;  // must be ignored
            end
        end
        checks++; if (!done) begin errors++; $display("FAIL clr_timeout: busy still %b after 3000 cycles", clear_busy); end
        checks++; if (busy_cnt != 2400) begin errors++; $display("FAIL clr_len: busy %0d cycles want 2400", busy_cnt); end
        checks++; if (saw_ready) begin errors++; $display("FAIL clr_ready: ready seen 1 want 0 during clear"); end
        checks++; if (req_ready !== 1'b1 || mem_addr !== 12'd7 || mem_we !== 1'b1) begin errors++; $display("FAIL clr_after: rdy=%b addr=%0d we=%b want 1/7/1", req_ready, mem_addr, mem_we); end
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
        #1;
        for (int a = 0; a < 2400; a++) begin
            if (vram[a] !== ((a == 7) ? 8'hAA : 8'h20)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL clr_cells: %0d cells wrong want 0", bad); end
        checks++; if (vram[2400] !== 8'h99) begin errors++; $display("FAIL clr_bound: cell 2400=%h want 99", vram[2400]); end
    endtask

    task automatic test_clear_display();
        int busy_cnt = 0;
        int slots = 0;
        int wr = 0;
        int bad = 0;
        int cbad = 0;
        bit done = 1'b0;
        host_write(12'd0, 8'h11);
        host_write(12'd2399, 8'h11);
        @(negedge clk);
        fetch_on = 1'b1; fetch_x = 10'd1; fetch_y = 9'd0; clear_start = 1'b1;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            clear_start = 1'b0;
            fetch_x = (fetch_x == 10'd639) ? 10'd0 : fetch_x + 10'd1;
            #1;
            if (!clear_busy) done = 1'b1;
            else begin
                busy_cnt++;
                if (fetch_x[2:0] == 3'd0) begin
                    slots++;
                    if (mem_we !== 1'b0) bad++;
                end else begin
                    if (mem_we !== 1'b1 || mem_addr !== 12'(wr) || mem_wdata !== 8'h20) bad++;
                    wr++;
                end
            end
        end
        fetch_on = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL clrd_timeout: busy still %b after 4000 cycles", clear_busy); end
        checks++; if (busy_cnt != 2400 + slots || slots == 0) begin errors++; $display("FAIL clrd_len: busy %0d slots %0d want busy=2400+slots", busy_cnt, slots); end
        checks++; if (bad != 0 || wr != 2400) begin errors++; $display("FAIL clrd_port: %0d bad cycles, %0d writes want 0/2400", bad, wr); end
        @(negedge clk);
        for (int a = 0; a < 2400; a++) if (vram[a] !== 8'h20) cbad++;
        checks++; if (cbad != 0) begin errors++; $display("FAIL clrd_cells: %0d cells wrong want 0", cbad); end
    endtask

    task automatic test_reset_mid();
        bit done = 1'b0;
        // host read in flight across reset
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 12'd5;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstm_accept: ready=%b want 1", req_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0; req_valid = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstm_rsp: rsp_valid=%b want 0", rsp_valid); end
        @(negedge clk);
        rst = 1'b1;
        // clear aborted at cell 100
        @(negedge clk);
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        repeat (100) @(negedge clk);
        #1;
        checks++; if (clear_busy !== 1'b1 || mem_addr !== 12'd100) begin errors++; $display("FAIL rstm_pos: busy=%b addr=%0d want 1/100", clear_busy, mem_addr); end
        rst = 1'b0; req_valid = 1'b1;
        #1;
        checks++; if (clear_busy !== 1'b0 || mem_en !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL rstm_abort: busy=%b en=%b rdy=%b want 0/0/0", clear_busy, mem_en, req_ready); end
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0; clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        #1;
        checks++; if (clear_busy !== 1'b1 || mem_addr !== 12'd0 || mem_we !== 1'b1 || mem_wdata !== 8'h20)
            begin errors++; $display("FAIL rstm_restart: busy=%b addr=%0d we=%b d=%h want 1/0/1/20", clear_busy, mem_addr, mem_we, mem_wdata); end
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk); #1;
            if (!clear_busy) done = 1'b1;
        end
        checks++; if (!done) begin errors++; $display("FAIL rstm_finish: busy still %b after 3000 cycles", clear_busy); end
    endtask

    initial begin
        test_reset();
        test_display();
        test_write_read();
        test_collision();
        test_clear_tie();
        test_clear_display();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
